// File: rtl/mul3_share_arbiter.sv
// mul3_share_arbiter: round-robin sharing of one 3x3 multiplier with a tagged valid/ready response
module mul3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] p
);
  assign p = {3'b000, a & {3{b[0]}}}
           + {2'b00, a & {3{b[1]}}, 1'b0}
           + {1'b0, a & {3{b[2]}}, 2'b00};
endmodule

module mul3_share_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] a_in,
  input  logic [3*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [5:0]        rsp_prod,
  input  logic              rsp_ready,
  output logic [7:0]        op_count
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t st;
  logic [IDW-1:0] last, win, cand;
  logic hit;
  logic [2:0] opa, opb;
  logic [5:0] prod;
  logic [2:0] a_arr [NREQ];
  logic [2:0] b_arr [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = a_in[3*g +: 3];
    assign b_arr[g] = b_in[3*g +: 3];
  end
  // search starts just after the last winner so the previous winner ranks lowest
  always_comb begin
    win = last;
    cand = last;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!hit && req[cand]) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end
  mul3 u_mul (.a(opa), .b(opb), .p(prod));
  assign busy = st != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      grant <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_prod <= '0;
      op_count <= '0;
      last <= IDW'(NREQ - 1);
      opa <= '0;
      opb <= '0;
    end else begin
      case (st)
        IDLE: if (hit) begin
          opa <= a_arr[win];
          opb <= b_arr[win];
          rsp_id <= win;
          grant <= NREQ'(1) << win;
          last <= win;
          st <= CALC;
        end
        CALC: begin
          rsp_prod <= prod;
          rsp_valid <= 1'b1;
          grant <= '0;
          st <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count <= op_count + 8'd1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul3_share_arbiter.sv
// tb_mul3_share_arbiter: scenario tasks checked against a round-robin/arithmetic reference model
module tb_mul3_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, rsp_ready, busy, rsp_valid;
  logic [N-1:0] req, grant;
  logic [3*N-1:0] a_in, b_in;
  logic [1:0] rsp_id;
  logic [5:0] rsp_prod;
  logic [7:0] op_count;
  logic [2:0] av [N];
  logic [2:0] bv [N];
  int pass_n = 0, total_n = 0, m_last, m_ops;

  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign a_in[3*g +: 3] = av[g];
    assign b_in[3*g +: 3] = bv[g];
  end

  mul3_share_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .grant(grant), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_ready(rsp_ready), .op_count(op_count)
  );

  function automatic int winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; req = '0; rsp_ready = 1'b0;
    step(); step();
    rst = 1'b0; m_last = N - 1; m_ops = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin av[i] = '0; bv[i] = '0; end
    reset_dut();
    total_n++; if (grant !== '0) $display("FAIL reset_grant got %b exp 0", grant); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_n++;
    total_n++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rsp_valid); else pass_n++;
    total_n++; if (rsp_id !== '0) $display("FAIL reset_id got %0d exp 0", rsp_id); else pass_n++;
    total_n++; if (rsp_prod !== '0) $display("FAIL reset_prod got %0d exp 0", rsp_prod); else pass_n++;
    total_n++; if (op_count !== '0) $display("FAIL reset_count got %0d exp 0", op_count); else pass_n++;
  endtask

  task automatic test_single();
    req = 4'b0001; av[0] = 3'd7; bv[0] = 3'd7; rsp_ready = 1'b1;
    step();
    total_n++; if ({grant, busy, rsp_valid} !== {4'b0001, 1'b1, 1'b0})
      $display("FAIL single_grant got grant=%b busy=%b valid=%b exp 0001/1/0", grant, busy, rsp_valid); else pass_n++;
    step();
    req = '0;
    total_n++; if ({grant, rsp_valid, rsp_id, rsp_prod} !== {4'b0000, 1'b1, 2'd0, 6'd49})
      $display("FAIL single_rsp got grant=%b valid=%b id=%0d prod=%0d exp 0000/1/0/49", grant, rsp_valid, rsp_id, rsp_prod); else pass_n++;
    step();
    m_last = 0; m_ops = 1;
    total_n++; if ({rsp_valid, busy, op_count} !== {1'b0, 1'b0, 8'd1})
      $display("FAIL single_done got valid=%b busy=%b count=%0d exp 0/0/1", rsp_valid, busy, op_count); else pass_n++;
  endtask

  task automatic run_full_ops(input int n, input string tag);
    int w, e;
    for (int op = 0; op < n; op++) begin
      w = winner(req, m_last);
      e = int'(av[w]) * int'(bv[w]);
      step();
      total_n++; if (grant !== onehot(w)) $display("FAIL %s_grant op %0d got %b exp %b", tag, op, grant, onehot(w)); else pass_n++;
      step();
      total_n++; if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 2'(w), 6'(e)})
        $display("FAIL %s_rsp op %0d got valid=%b id=%0d prod=%0d exp 1/%0d/%0d", tag, op, rsp_valid, rsp_id, rsp_prod, w, e); else pass_n++;
      av[w] = 3'($urandom); bv[w] = 3'($urandom);
      m_last = w; m_ops++;
      step();
      total_n++; if ({rsp_valid, op_count} !== {1'b0, 8'(m_ops)})
        $display("FAIL %s_count op %0d got valid=%b count=%0d exp 0/%0d", tag, op, rsp_valid, op_count, m_ops % 256); else pass_n++;
    end
  endtask

  task automatic test_rotation();
    reset_dut();
    for (int i = 0; i < N; i++) begin av[i] = 3'(i + 2); bv[i] = 3'(7 - i); end
    req = '1; rsp_ready = 1'b1;
    run_full_ops(5, "rot");
    total_n++; if (op_count !== 8'd5) $display("FAIL rot_total got %0d exp 5", op_count); else pass_n++;
    req = '0;
  endtask

  task automatic test_stall();
    int e, w;
    req = 4'b0100; rsp_ready = 1'b0; av[2] = 3'($urandom); bv[2] = 3'($urandom);
    e = int'(av[2]) * int'(bv[2]);
    step();
    total_n++; if (grant !== 4'b0100) $display("FAIL stall_grant got %b exp 0100", grant); else pass_n++;
    req = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      step();
      total_n++; if ({rsp_valid, rsp_id, rsp_prod, busy, grant} !== {1'b1, 2'd2, 6'(e), 1'b1, 4'b0000})
        $display("FAIL stall_hold cyc %0d got valid=%b id=%0d prod=%0d busy=%b grant=%b exp 1/2/%0d/1/0000",
                 c, rsp_valid, rsp_id, rsp_prod, busy, grant, e); else pass_n++;
    end
    rsp_ready = 1'b1;
    step();
    m_last = 2; m_ops++;
    total_n++; if ({rsp_valid, op_count} !== {1'b0, 8'(m_ops)})
      $display("FAIL stall_release got valid=%b count=%0d exp 0/%0d", rsp_valid, op_count, m_ops); else pass_n++;
    w = winner(req, m_last);
    step();
    total_n++; if (grant !== 4'b0001) $display("FAIL stall_next got %b exp 0001", grant); else pass_n++;
    req = '0;
    step(); step();
    m_last = w; m_ops++;
    step();
    total_n++; if ({grant, busy} !== {4'b0000, 1'b0})
      $display("FAIL drop_idle got grant=%b busy=%b exp 0000/0", grant, busy); else pass_n++;
    req = 4'b0011;
    run_full_ops(1, "drop_ptr");
    req = '0;
  endtask

  task automatic test_exhaustive();
    req = 4'b1000; rsp_ready = 1'b1;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        av[3] = 3'(a); bv[3] = 3'(b);
        step();
        total_n++; if (grant !== 4'b1000) $display("FAIL exh_grant %0d*%0d got %b exp 1000", a, b, grant); else pass_n++;
        step();
        total_n++; if ({rsp_id, rsp_prod} !== {2'd3, 6'(a * b)})
          $display("FAIL exh_prod %0d*%0d got id=%0d prod=%0d exp 3/%0d", a, b, rsp_id, rsp_prod, a * b); else pass_n++;
        step();
        m_last = 3; m_ops++;
      end
    total_n++; if (op_count !== 8'(m_ops)) $display("FAIL exh_count got %0d exp %0d", op_count, m_ops % 256); else pass_n++;
    req = '0;
  endtask

  task automatic test_random();
    int w, e, d;
    for (int op = 0; op < 40; op++) begin
      req = N'($urandom_range(1, (1 << N) - 1)); rsp_ready = 1'($urandom);
      for (int i = 0; i < N; i++) begin av[i] = 3'($urandom); bv[i] = 3'($urandom); end
      w = winner(req, m_last);
      e = int'(av[w]) * int'(bv[w]);
      step();
      total_n++; if ({grant, busy} !== {onehot(w), 1'b1})
        $display("FAIL rnd_grant op %0d got %b busy=%b exp %b/1", op, grant, busy, onehot(w)); else pass_n++;
      req = N'($urandom);
      step();
      d = rsp_ready ? 0 : $urandom_range(0, 3);
      for (int c = 0; c <= d; c++) begin
        if (c > 0) step();
        total_n++; if ({rsp_valid, rsp_id, rsp_prod, grant} !== {1'b1, 2'(w), 6'(e), 4'b0000})
          $display("FAIL rnd_rsp op %0d got valid=%b id=%0d prod=%0d grant=%b exp 1/%0d/%0d/0000",
                   op, rsp_valid, rsp_id, rsp_prod, grant, w, e); else pass_n++;
      end
      rsp_ready = 1'b1; req = '0;
      step();
      m_last = w; m_ops++;
      total_n++; if ({rsp_valid, op_count} !== {1'b0, 8'(m_ops)})
        $display("FAIL rnd_count op %0d got valid=%b count=%0d exp 0/%0d", op, rsp_valid, op_count, m_ops % 256); else pass_n++;
    end
  endtask

  task automatic test_rst_calc();
    req = 4'b0001; rsp_ready = 1'b1;
    step();
    total_n++; if (grant !== onehot(winner(req, m_last))) $display("FAIL rstc_grant got %b exp 0001", grant); else pass_n++;
    rst = 1'b1; req = '0;
    step();
    total_n++; if ({grant, busy, rsp_valid, rsp_id, rsp_prod, op_count} !== '0)
      $display("FAIL rstc_clear got grant=%b busy=%b valid=%b id=%0d prod=%0d count=%0d exp all 0",
               grant, busy, rsp_valid, rsp_id, rsp_prod, op_count); else pass_n++;
    rst = 1'b0; m_last = N - 1; m_ops = 0;
    req = 4'b0011;
    run_full_ops(1, "rstc_ptr");
    req = '0;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < N; i++) begin av[i] = 3'($urandom); bv[i] = 3'($urandom); end
    req = '1; rsp_ready = 1'b1;
    run_full_ops(256, "b2b");
    total_n++; if (op_count !== 8'd0) $display("FAIL wrap_count got %0d exp 0", op_count); else pass_n++;
    run_full_ops(3, "post_wrap");
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_stall();
    test_exhaustive();
    test_random();
    test_rst_calc();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
